// File: rtl/aes128_enc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// aes128_enc_ctrl_pkg
// Shared definitions for the iterative AES-128 encryption controller:
//   - FSM state encodings (IDLE / RUN / DONE)
//   - NR_AES128: the only legal round count
//   - S-box lookup, round-constant table, xtime and MixColumn helpers
// Byte order everywhere: byte0 = bits[127:120], column-major state.
// -----------------------------------------------------------------------------
package aes128_enc_ctrl_pkg;

  localparam int NR_AES128 = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x); 255-x is simply ~x for an 8-bit x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  // Round constant for rounds 1..10; anything else yields 0.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column: rows {2,3,1,1} rotated.
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes128_enc_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes128_enc_ctrl_if
// Block-level handshake bundle of the AES-128 controller.
//   in_valid/in_ready/in_block/in_key    : plaintext + key source side
//   out_valid/out_ready/out_block        : ciphertext sink side
//   busy, round                          : status
// slave  : the controller's view
// master : the view of whatever drives the controller (source + sink)
// -----------------------------------------------------------------------------
interface aes128_enc_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round;

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block, busy, round
  );

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block, busy, round
  );
endinterface

// File: rtl/aes128_enc_ctrl_key_step.sv
// -----------------------------------------------------------------------------
// aes128_enc_ctrl_key_step
// Combinational AES-128 key-expansion step: one round key to the next.
//   i_key  [127:0] current round key (w0..w3, w0 in the MSBs)
//   i_rcon [7:0]   round constant for the round being produced
//   o_key  [127:0] next round key
// -----------------------------------------------------------------------------
module aes128_enc_ctrl_key_step
  import aes128_enc_ctrl_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;

  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_t   = w_sub ^ {i_rcon, 24'h000000};

  // Each word folds in the freshly computed previous word.
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_enc_ctrl.sv
// -----------------------------------------------------------------------------
// aes128_enc_ctrl
// Iterative AES-128 encryption: one full round per clock, key expanded on the
// fly. IDLE accepts a block, RUN applies rounds 1..10, DONE presents the
// ciphertext until the sink takes it.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : aes128_enc_ctrl_if.slave (in_*/out_* handshakes, busy, round)
// Parameters:
//   NR        : round count, must be 10
//   CLEAR_OUT : 1 drives out_block to 0 whenever out_valid is low
// -----------------------------------------------------------------------------
module aes128_enc_ctrl
  import aes128_enc_ctrl_pkg::*;
#(
  parameter int NR        = 10,
  parameter bit CLEAR_OUT = 1'b1
)(
  input  logic                    clk,
  input  logic                    rst_n,
  aes128_enc_ctrl_if.slave        bus
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes128_enc_ctrl: NR must be 10 (AES-128)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic [1:0]   r_fsm;

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_key_next;
  logic [7:0]   w_rcon;
  logic         w_last;
  logic         w_out_valid;

  // SubBytes: 16 parallel S-boxes on the current state.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign w_sb[127-8*gi -: 8] = sbox(r_state[127-8*gi -: 8]);
  end

  // ShiftRows is pure wiring: byte (row r, col c) takes byte (r, (c+r) mod 4).
  // MixColumns then works on each 32-bit column.
  for (genvar gc = 0; gc < 4; gc++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      assign w_sr[127-8*(gr+4*gc) -: 8] = w_sb[127-8*(gr+4*((gc+gr)%4)) -: 8];
    end
    assign w_mc[127-32*gc -: 32] = mix_column(w_sr[127-32*gc -: 32]);
  end

  assign w_rcon = rcon(r_round);

  aes128_enc_ctrl_key_step u_key_step (
    .i_key  (r_key),
    .i_rcon (w_rcon),
    .o_key  (w_key_next)
  );

  // ">=" rather than "==" so the counter can never run past NR.
  assign w_last = (r_round >= LAST_ROUND);

  // NOTE: state registers use non-blocking assignments so every branch reads
  // the pre-edge values of r_state/r_key/r_round regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state <= bus.in_block ^ bus.in_key;
            r_key   <= bus.in_key;
            r_round <= 4'd1;
            r_fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_key <= w_key_next;
          if (w_last) begin
            // Final round skips MixColumns; round stays at NR while in DONE.
            r_state <= w_sr ^ w_key_next;
            r_fsm   <= ST_DONE;
          end else begin
            r_state <= w_mc ^ w_key_next;
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_fsm   <= ST_IDLE;
            r_round <= '0;
          end
        end
        default: begin
          r_fsm   <= ST_IDLE;
          r_round <= '0;
        end
      endcase
    end
  end

  assign w_out_valid   = (r_fsm == ST_DONE);
  assign bus.in_ready  = (r_fsm == ST_IDLE);
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = (r_fsm == ST_RUN) || (r_fsm == ST_DONE);
  assign bus.round     = r_round;
  assign bus.out_block = (CLEAR_OUT && !w_out_valid) ? '0 : r_state;

endmodule
